// File: rtl/alu_pkg.sv
// Shared definitions for the EX stage: ALU op codes (common with the ALU-control
// decoder), mul/div engine state encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_MULT = 5'd10;
  localparam logic [4:0] OP_DIV  = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd12;
  localparam logic [4:0] OP_MFLO = 5'd13;
  localparam logic [4:0] OP_MTHI = 5'd14;
  localparam logic [4:0] OP_MTLO = 5'd15;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  // Ops that produce a GPR write-back through out_result.
  function automatic logic writes_gpr(input logic [4:0] op);
    return (op <= OP_SLT) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: one bit per cycle, then a sign-fixup cycle.
// State | meaning
// MD_IDLE | waiting for start; busy=0
// MD_MUL  | shift-add multiply, one multiplier bit per cycle
// MD_DIV  | restoring divide, one quotient bit per cycle
// MD_FIX  | sign correction presented on hi_res/lo_res, done=1
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d;
  logic             is_div_q, is_div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_sub;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    mag_a     = (sign && a[WIDTH-1]) ? -a : a;
    mag_b     = (sign && b[WIDTH-1]) ? -b : b;
    sum_ext   = {1'b0, acc_hi_q} + {1'b0, mcand_q};
    trial     = {acc_hi_q, acc_lo_q[WIDTH-1]};
    trial_sub = trial - {1'b0, mcand_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    a_raw_d   = a_raw_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    busy_d    = busy_q;
    done_d    = done_q;

    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          state_d   = op ? MD_DIV : MD_MUL;
          busy_d    = 1'b1;
          cnt_d     = CW'(ITER - 1);
          acc_hi_d  = '0;
          acc_lo_d  = op ? mag_a : mag_b;
          mcand_d   = op ? mag_b : mag_a;
          a_raw_d   = a;
          neg_d     = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_d = sign & a[WIDTH-1];
          div0_d    = op & (b == '0);
          is_div_d  = op;
        end
      end
      MD_MUL: begin
        if (acc_lo_q[0]) begin
          acc_hi_d = sum_ext[WIDTH:1];
          acc_lo_d = {sum_ext[0], acc_lo_q[WIDTH-1:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[WIDTH-1:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = MD_FIX;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DIV: begin
        // Partial remainder stays below the divisor, so the trial fits WIDTH+1 bits.
        if (trial >= {1'b0, mcand_q}) begin
          acc_hi_d = trial_sub[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = trial[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = MD_FIX;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase

    if (flush && state_q != MD_IDLE) begin
      state_d = MD_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      a_raw_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      a_raw_q   <= a_raw_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
    if (!is_div_q) begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end else if (div0_q) begin
      hi_res = a_raw_q;
      lo_res = '1;
    end else begin
      // Most-negative / -1 falls out naturally: magnitude quotient is already 0x8000_0000.
      hi_res = rem_neg_q ? -acc_hi_q : acc_hi_q;
      lo_res = neg_q ? -acc_lo_q : acc_lo_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage datapath: single-cycle ALU with registered result, HI/LO registers and
// an iterative mul/div engine. Define OVERFLOW_TRAP_EN to enable signed ADD/SUB out_ovf.
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       shamt,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept;
  logic             md_start;
  logic             md_busy, md_done;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             lt;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  assign in_ready = !md_busy;
  assign busy     = md_busy;
  assign accept   = in_valid && in_ready && !flush;
  assign md_start = accept && (ALUCtrl == OP_MULT || ALUCtrl == OP_DIV);

  always_comb begin
    sum  = in_a + in_b;
    diff = in_a - in_b;
    lt   = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
    case (ALUCtrl)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_NOR:  alu_res = ~(in_a | in_b);
      OP_SLL:  alu_res = in_b << shamt;
      OP_SRL:  alu_res = in_b >> shamt;
      OP_SRA:  alu_res = $signed(in_b) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    out_valid_d  = accept && writes_gpr(ALUCtrl);
    out_result_d = out_valid_d ? alu_res : out_result_q;

    hi_d = hi_q;
    lo_d = lo_q;
    // A flush landing in the fixup cycle discards the engine result.
    if (md_done && !flush) begin
      hi_d = hi_res;
      lo_d = lo_res;
    end else if (accept && ALUCtrl == OP_MTHI) begin
      hi_d = in_a;
    end else if (accept && ALUCtrl == OP_MTLO) begin
      lo_d = in_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  logic out_ovf_q, out_ovf_d;
  logic ovf_add, ovf_sub;

  always_comb begin
    ovf_add   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    ovf_sub   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
    out_ovf_d = accept && Sign &&
                ((ALUCtrl == OP_ADD && ovf_add) || (ALUCtrl == OP_SUB && ovf_sub));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_ovf_q <= 1'b0;
    else        out_ovf_q <= out_ovf_d;
  end

  assign out_ovf = out_ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  muldiv_iter #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .flush  (flush),
    .op     (ALUCtrl == OP_DIV),
    .sign   (Sign),
    .a      (in_a),
    .b      (in_b),
    .busy   (md_busy),
    .done   (md_done),
    .hi_res (hi_res),
    .lo_res (lo_res)
  );

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
